// File: rtl/shift_frame_sequencer_pkg.sv
// Shared definitions for the shift-register frame sequencer: FSM state encoding
// and a width helper for counters that must stay at least one bit wide.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_frame_sequencer_if.sv
// Valid/ready word handshake between a packet source (master) and the
// frame sequencer (slave).
interface shift_frame_sequencer_if #(
  parameter int SHIFT_WIDTH = 8
) ();
  logic [SHIFT_WIDTH-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/param_shift_register.sv
// Parallel-load shift register datapath driven by the frame sequencer.
// sclr clears regardless of enable; load and shift only act while enabled.
module param_shift_register #(
  parameter int    SHIFT_WIDTH     = 8,
  parameter string SHIFT_DIRECTION = "LEFT"
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   sclr,
  input  logic                   load,
  input  logic                   enable,
  input  logic                   shiftin,
  input  logic [SHIFT_WIDTH-1:0] data,
  output logic [SHIFT_WIDTH-1:0] q,
  output logic                   shiftout
);
  logic [SHIFT_WIDTH-1:0] q_reg;
  logic [SHIFT_WIDTH-1:0] shifted;

  generate
    if (SHIFT_DIRECTION == "RIGHT") begin : g_right
      assign shifted  = {shiftin, q_reg[SHIFT_WIDTH-1:1]};
      assign shiftout = q_reg[0];
    end else begin : g_left
      assign shifted  = {q_reg[SHIFT_WIDTH-2:0], shiftin};
      assign shiftout = q_reg[SHIFT_WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      q_reg <= '0;
    end else if (sclr) begin
      q_reg <= '0;
    end else if (enable) begin
      q_reg <= load ? data : shifted;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/shift_frame_sequencer_bit_timer.sv
// Bit-period and bit-index counters for the serial frame. The *_next outputs
// expose the post-edge tick/last decode so the owner can register its strobes.
module shift_bit_timer
  import shift_ctrl_pkg::*;
#(
  parameter int SHIFT_WIDTH  = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic aclr,
  input  logic en,
  input  logic clr,
  output logic bit_tick,
  output logic last_bit,
  output logic tick_next,
  output logic last_next
);
  localparam int CW = clog2_min1(CLKS_PER_BIT);
  localparam int BW = clog2_min1(SHIFT_WIDTH);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SHIFT_WIDTH - 1);

  logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;

  assign bit_tick = (clk_cnt_reg == CLK_LAST);
  assign last_bit = (bit_cnt_reg == BIT_LAST);

  // Counters stop at their terminal values; leaving SHIFT clears them.
  always_comb begin
    clk_cnt_next = clk_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    if (clr) begin
      clk_cnt_next = '0;
      bit_cnt_next = '0;
    end else if (en) begin
      if (bit_tick) begin
        clk_cnt_next = '0;
        if (!last_bit) bit_cnt_next = bit_cnt_reg + BW'(1);
      end else begin
        clk_cnt_next = clk_cnt_reg + CW'(1);
      end
    end
  end

  assign tick_next = (clk_cnt_next == CLK_LAST);
  assign last_next = (bit_cnt_next == BIT_LAST);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
    end else begin
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end
endmodule

// File: rtl/shift_frame_sequencer.sv
// Frame sequencer: accepts a word, loads the shift register, clocks it out MSB
// first at CLKS_PER_BIT cycles per bit, then holds the line idle for GAP_CYCLES.
module shift_frame_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int SHIFT_WIDTH  = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_CYCLES   = 2,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input  logic                   clock,
  input  logic                   aclr,
  shift_frame_sequencer_if.slave tx,
  input  logic                   abort,
  output logic                   sr_load,
  output logic                   sr_enable,
  output logic                   sr_sclr,
  output logic                   sr_shiftin,
  output logic [SHIFT_WIDTH-1:0] sr_data,
  input  logic                   sr_shiftout,
  output logic                   serial_out,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int GW = clog2_min1(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t                 state_reg, state_next;
  logic [GW-1:0]          gap_cnt_reg, gap_cnt_next;
  logic [SHIFT_WIDTH-1:0] sr_data_reg, sr_data_next;
  logic sr_load_reg, sr_load_next;
  logic sr_enable_reg, sr_enable_next;
  logic sr_sclr_reg, sr_sclr_next;
  logic frame_done_reg, frame_done_next;
  logic bit_tick, last_bit, tick_next, last_next;

  shift_bit_timer #(
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock    (clock),
    .aclr     (aclr),
    .en       (state_reg == SHIFT),
    .clr      (state_next != SHIFT),
    .bit_tick (bit_tick),
    .last_bit (last_bit),
    .tick_next(tick_next),
    .last_next(last_next)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (tx.tx_valid) state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: begin
        if (bit_tick && last_bit) begin
          if (GAP_CYCLES == 0) state_next = IDLE;
          else                 state_next = GAP;
        end
      end
      GAP:   if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state_reg != IDLE)) state_next = IDLE;
  end

  // Strobes are computed from the state being entered so they are registered
  // yet line up with that state; the final bit period gets no shift pulse.
  always_comb begin
    gap_cnt_next    = ((state_reg == GAP) && (state_next == GAP)) ? gap_cnt_reg + GW'(1) : '0;
    sr_data_next    = ((state_reg == IDLE) && tx.tx_valid) ? tx.tx_data : sr_data_reg;
    sr_load_next    = (state_next == LOAD);
    sr_enable_next  = (state_next == LOAD) ||
                      ((state_next == SHIFT) && tick_next && !last_next);
    sr_sclr_next    = abort && (state_reg != IDLE);
    frame_done_next = !abort && (state_next == IDLE) &&
                      ((state_reg == SHIFT) || (state_reg == GAP));
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_reg      <= IDLE;
      gap_cnt_reg    <= '0;
      sr_data_reg    <= '0;
      sr_load_reg    <= 1'b0;
      sr_enable_reg  <= 1'b0;
      sr_sclr_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gap_cnt_reg    <= gap_cnt_next;
      sr_data_reg    <= sr_data_next;
      sr_load_reg    <= sr_load_next;
      sr_enable_reg  <= sr_enable_next;
      sr_sclr_reg    <= sr_sclr_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign tx.tx_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign serial_out  = (state_reg == SHIFT) ? sr_shiftout : IDLE_LEVEL;
  assign sr_shiftin  = IDLE_LEVEL;
  assign sr_data     = sr_data_reg;
  assign sr_load     = sr_load_reg;
  assign sr_enable   = sr_enable_reg;
  assign sr_sclr     = sr_sclr_reg;
  assign frame_done  = frame_done_reg;
endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Bench: default sequencer (8 bits, 4 clk/bit, 2-cycle gap) and a fast variant
// (1 clk/bit, no gap), each driving a left-shifting register.
module tb_shift_frame_sequencer;
  logic clock;
  logic aclr;
  logic abort_a, abort_b;
  logic sr_load_a, sr_enable_a, sr_sclr_a, sr_shiftin_a, sr_shiftout_a;
  logic serial_out_a, busy_a, frame_done_a;
  logic [7:0] sr_data_a, sr_q_a;
  logic sr_load_b, sr_enable_b, sr_sclr_b, sr_shiftin_b, sr_shiftout_b;
  logic serial_out_b, busy_b, frame_done_b;
  logic [7:0] sr_data_b, sr_q_b;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
  } vec_t;
  vec_t vecs[5];

  shift_frame_sequencer_if #(.SHIFT_WIDTH(8)) if_a ();
  shift_frame_sequencer_if #(.SHIFT_WIDTH(8)) if_b ();

  shift_frame_sequencer #(
    .SHIFT_WIDTH(8), .CLKS_PER_BIT(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)
  ) dut_a (
    .clock(clock), .aclr(aclr), .tx(if_a), .abort(abort_a),
    .sr_load(sr_load_a), .sr_enable(sr_enable_a), .sr_sclr(sr_sclr_a),
    .sr_shiftin(sr_shiftin_a), .sr_data(sr_data_a), .sr_shiftout(sr_shiftout_a),
    .serial_out(serial_out_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  param_shift_register #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("LEFT")) reg_a (
    .clock(clock), .aclr(aclr), .sclr(sr_sclr_a), .load(sr_load_a),
    .enable(sr_enable_a), .shiftin(sr_shiftin_a), .data(sr_data_a),
    .q(sr_q_a), .shiftout(sr_shiftout_a)
  );

  shift_frame_sequencer #(
    .SHIFT_WIDTH(8), .CLKS_PER_BIT(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .clock(clock), .aclr(aclr), .tx(if_b), .abort(abort_b),
    .sr_load(sr_load_b), .sr_enable(sr_enable_b), .sr_sclr(sr_sclr_b),
    .sr_shiftin(sr_shiftin_b), .sr_data(sr_data_b), .sr_shiftout(sr_shiftout_b),
    .serial_out(serial_out_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  param_shift_register #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("LEFT")) reg_b (
    .clock(clock), .aclr(aclr), .sclr(sr_sclr_b), .load(sr_load_b),
    .enable(sr_enable_b), .shiftin(sr_shiftin_b), .data(sr_data_b),
    .q(sr_q_b), .shiftout(sr_shiftout_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Entered at a negedge in IDLE with tx_valid already driven; leaves at the
  // negedge of the first IDLE cycle after the frame.
  task automatic frame_a(input logic [7:0] exp_bits, input bit chain, input logic [7:0] next_data);
    logic b;
    int en_cnt;
    for (int i = 7; i >= 0; i--) exp_q.push_back(exp_bits[i]);
    @(negedge clock);
    chk1("load_sr_load", sr_load_a, 1'b1);
    chk1("load_sr_enable", sr_enable_a, 1'b1);
    chk1("load_sr_sclr", sr_sclr_a, 1'b0);
    chk1("load_tx_ready", if_a.tx_ready, 1'b0);
    chk1("load_serial", serial_out_a, 1'b1);
    chk8("load_sr_data", sr_data_a, exp_bits);
    abort_a = 1'b0;
    if (chain) begin
      if_a.tx_data = next_data;
    end else begin
      if_a.tx_valid = 1'b0;
      if_a.tx_data  = ~if_a.tx_data;
    end
    en_cnt = 0;
    b = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      if (k % 4 == 0) b = exp_q.pop_front();
      chk1($sformatf("serial_%h_k%0d", exp_bits, k), serial_out_a, b);
      chk1($sformatf("enable_%h_k%0d", exp_bits, k), sr_enable_a, (k % 4 == 3) && (k < 28));
      chk1($sformatf("busy_done_%h_k%0d", exp_bits, k), busy_a && !frame_done_a, 1'b1);
      if (sr_enable_a) en_cnt++;
    end
    chkn("enable_pulses", en_cnt, 7);
    for (int g = 0; g < 2; g++) begin
      @(negedge clock);
      chk1($sformatf("gap_serial_g%0d", g), serial_out_a, 1'b1);
      chk1($sformatf("gap_ready_g%0d", g), if_a.tx_ready, 1'b0);
      chk1($sformatf("gap_done_g%0d", g), frame_done_a, 1'b0);
    end
    @(negedge clock);
    chk1("end_frame_done", frame_done_a, 1'b1);
    chk1("end_tx_ready", if_a.tx_ready, 1'b1);
    chk1("end_busy", busy_a, 1'b0);
    chk8("end_sr_data_held", sr_data_a, exp_bits);
    $display("frame data=%h sent, enables=%0d", exp_bits, en_cnt);
  endtask

  initial begin
    logic b;
    vecs[0] = '{8'hDB, 8'b11011011};
    vecs[1] = '{8'h81, 8'b10000001};
    vecs[2] = '{8'h00, 8'b00000000};
    vecs[3] = '{8'hFF, 8'b11111111};
    vecs[4] = '{8'h5A, 8'b01011010};

    aclr = 1'b1;
    abort_a = 1'b0;
    abort_b = 1'b0;
    if_a.tx_valid = 1'b0;
    if_a.tx_data  = 8'h00;
    if_b.tx_valid = 1'b0;
    if_b.tx_data  = 8'h00;
    repeat (2) @(negedge clock);
    chk1("rst_tx_ready", if_a.tx_ready, 1'b1);
    chk1("rst_serial", serial_out_a, 1'b1);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_strobes", sr_load_a | sr_enable_a | sr_sclr_a | frame_done_a, 1'b0);
    chk8("rst_sr_data", sr_data_a, 8'h00);
    chk1("rst_shiftin", sr_shiftin_a, 1'b1);
    chk1("rst_b_shiftin", sr_shiftin_b, 1'b1);
    chk8("rst_b_q", sr_q_b, 8'h00);
    $display("reset checked");
    aclr = 1'b0;
    @(negedge clock);

    // Single-word frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      if_a.tx_valid = 1'b1;
      if_a.tx_data  = vecs[v].data;
      frame_a(vecs[v].exp_bits, 1'b0, 8'h00);
      @(negedge clock);
      chk1($sformatf("done_one_cycle_%0d", v), frame_done_a, 1'b0);
    end

    // Back-to-back frames with tx_valid held high.
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'hA5;
    frame_a(8'hA5, 1'b1, 8'h3C);
    frame_a(8'h3C, 1'b0, 8'h00);
    @(negedge clock);

    // Abort during the third bit of 0xF0.
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'hF0;
    @(negedge clock);
    chk1("abort_load", sr_load_a, 1'b1);
    if_a.tx_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk1("abort_pre_serial", serial_out_a, 1'b1);
    abort_a = 1'b1;
    @(negedge clock);
    chk1("abort_sclr", sr_sclr_a, 1'b1);
    chk1("abort_idle", if_a.tx_ready, 1'b1);
    chk1("abort_busy", busy_a, 1'b0);
    chk1("abort_no_done", frame_done_a, 1'b0);
    abort_a = 1'b0;
    @(negedge clock);
    chk1("abort_sclr_pulse", sr_sclr_a, 1'b0);
    chk1("abort_no_done_late", frame_done_a, 1'b0);
    chk8("abort_reg_cleared", sr_q_a, 8'h00);
    $display("abort of frame data=f0 checked");
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'h81;
    frame_a(8'h81, 1'b0, 8'h00);
    @(negedge clock);

    // tx_valid and abort together in IDLE: the word is taken.
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'h69;
    abort_a = 1'b1;
    frame_a(8'h69, 1'b0, 8'h00);
    @(negedge clock);

    // Asynchronous reset in the middle of a frame.
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'hC3;
    @(negedge clock);
    if_a.tx_valid = 1'b0;
    repeat (6) @(negedge clock);
    aclr = 1'b1;
    #1;
    chk1("aclr_tx_ready", if_a.tx_ready, 1'b1);
    chk1("aclr_serial", serial_out_a, 1'b1);
    chk1("aclr_busy", busy_a, 1'b0);
    chk1("aclr_strobes", sr_load_a | sr_enable_a | sr_sclr_a | frame_done_a, 1'b0);
    chk8("aclr_sr_data", sr_data_a, 8'h00);
    @(negedge clock);
    aclr = 1'b0;
    begin
      int done_seen;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        if (frame_done_a) done_seen++;
      end
      chkn("aclr_no_frame_done", done_seen, 0);
    end
    $display("mid-frame reset checked");

    // Fast variant: one clock per bit, no gap.
    if_b.tx_valid = 1'b1;
    if_b.tx_data  = 8'h96;
    for (int i = 7; i >= 0; i--) exp_q.push_back(1'((8'h96 >> i) & 8'h01));
    @(negedge clock);
    chk1("b_load", sr_load_b, 1'b1);
    chk8("b_sr_data", sr_data_b, 8'h96);
    if_b.tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      b = exp_q.pop_front();
      chk1($sformatf("b_serial_k%0d", k), serial_out_b, b);
      chk1($sformatf("b_enable_k%0d", k), sr_enable_b, k < 7);
      chk1($sformatf("b_ready_k%0d", k), if_b.tx_ready, 1'b0);
    end
    @(negedge clock);
    chk1("b_ready_after", if_b.tx_ready, 1'b1);
    chk1("b_frame_done", frame_done_b, 1'b1);
    chk1("b_busy_after", busy_b, 1'b0);
    chk1("b_serial_idle", serial_out_b, 1'b1);
    chk1("b_no_sclr", sr_sclr_b, 1'b0);
    $display("fast frame data=96 sent");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
